// File: rtl/prince_ctr_ctrl.sv
// prince_ctr_ctrl: CTR-mode wrapper around a fixed-latency PRINCE core
// Ports: clk, sys_rst (async, active-high); start/stop control pulses; iv_in initial counter block;
//   s_valid/s_ready/s_data input stream; cipher_gen_en/ctr_block to the core, cipher_text keystream back;
//   m_valid/m_ready/m_data output stream (s_data ^ keystream); busy in RUN/DRAIN; wrap_err sticky wrap flag.
// Optional: define PRINCE_CTR_WRAP_GUARD_EN to stop issuing after the counter field reaches all-ones.
module prince_ctr_ctrl #(
  parameter int CIPHER_WIDTH   = 64,
  parameter int CIPHER_LATENCY = 5,
  parameter int CTR_WIDTH      = 32,
  parameter int OUT_DEPTH      = 8
) (
  input  logic                    clk,
  input  logic                    sys_rst,
  input  logic                    start,
  input  logic                    stop,
  input  logic [CIPHER_WIDTH-1:0] iv_in,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [CIPHER_WIDTH-1:0] s_data,
  output logic                    cipher_gen_en,
  output logic [CIPHER_WIDTH-1:0] ctr_block,
  input  logic [CIPHER_WIDTH-1:0] cipher_text,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [CIPHER_WIDTH-1:0] m_data,
  output logic                    busy,
  output logic                    wrap_err
);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2;
  localparam int OW = $clog2(CIPHER_LATENCY + OUT_DEPTH + 1);
  localparam int PW = $clog2(OUT_DEPTH);
  localparam int CNTW = PW + 1;
  localparam logic [CIPHER_WIDTH-1:0] LOW_MASK = {CIPHER_WIDTH{1'b1}} >> (CIPHER_WIDTH - CTR_WIDTH);
  logic [1:0] state, state_nxt;
  logic [CIPHER_WIDTH-1:0] iv_reg;
  logic [CTR_WIDTH-1:0] ctr, low;
  logic [CIPHER_LATENCY-1:0] vld;
  logic [CIPHER_WIDTH-1:0] dl [CIPHER_LATENCY];
  logic [CIPHER_WIDTH-1:0] mem [OUT_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CNTW-1:0] count;
  logic [OW-1:0] inflight;
  logic issue, push, pop, room;
  always_comb begin
    inflight = '0;
    for (int i = 0; i < CIPHER_LATENCY; i++) inflight = inflight + OW'(vld[i]);
  end
  // Credit: every issued block already owns a FIFO slot, so the keystream can never be dropped.
  assign room          = (inflight + OW'(count)) < OW'(OUT_DEPTH);
  assign low           = iv_reg[CTR_WIDTH-1:0] + ctr;
  assign ctr_block     = (iv_reg & ~LOW_MASK) | CIPHER_WIDTH'(low);
  assign s_ready       = (state == RUN) && room && !wrap_err;
  assign issue         = s_valid && s_ready;
  assign cipher_gen_en = issue;
  assign push          = vld[CIPHER_LATENCY-1];
  assign m_valid       = count != '0;
  assign pop           = m_valid && m_ready;
  assign m_data        = m_valid ? mem[rd_ptr] : '0;
  assign busy          = state != IDLE;
  always_comb
    state_nxt = (state == IDLE && start) ? RUN :
                (state == RUN && stop) ? DRAIN :
                (state == DRAIN && inflight == '0 && count == '0) ? IDLE : state;
  always_ff @(posedge clk or posedge sys_rst)
    if (sys_rst) begin
      state  <= IDLE;
      iv_reg <= '0;
      ctr    <= '0;
      vld    <= '0;
      for (int i = 0; i < CIPHER_LATENCY; i++) dl[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        iv_reg <= iv_in;
        ctr    <= '0;
      end else if (issue) ctr <= ctr + CTR_WIDTH'(1);
      vld[0] <= issue;
      dl[0]  <= s_data;
      for (int i = 1; i < CIPHER_LATENCY; i++) begin
        vld[i] <= vld[i-1];
        dl[i]  <= dl[i-1];
      end
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CNTW'(push) - CNTW'(pop);
    end
  // The delay-line tap lines up with the keystream of the block issued CIPHER_LATENCY cycles ago.
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= dl[CIPHER_LATENCY-1] ^ cipher_text;
`ifdef PRINCE_CTR_WRAP_GUARD_EN
  // Trips once the counter field of an issued block is all-ones; the next block would repeat keystream.
  always_ff @(posedge clk or posedge sys_rst)
    if (sys_rst) wrap_err <= 1'b0;
    else if (state == IDLE && start) wrap_err <= 1'b0;
    else if (issue && low == '1) wrap_err <= 1'b1;
`else
  assign wrap_err = 1'b0;
`endif
  overflow_chk: assert property (@(posedge clk) disable iff (sys_rst) !(push && count == CNTW'(OUT_DEPTH) && !pop));
endmodule

// File: tb/tb_prince_ctr_ctrl.sv
// tb_prince_ctr_ctrl: randomized self-checking bench for prince_ctr_ctrl with a keystream core model
module tb_prince_ctr_ctrl;
  localparam int W = 64, LAT = 5, CW = 32, DEPTH = 8;
  typedef struct { logic [W-1:0] data; int due; } exp_t;
  typedef struct { logic [W-1:0] ks; int due; } core_t;
  logic clk = 1'b0, sys_rst = 1'b0, start = 1'b0, stop = 1'b0, s_valid = 1'b0, m_ready = 1'b0;
  logic [W-1:0] iv_in = '0, s_data = '0, cipher_text = '0;
  logic s_ready, cipher_gen_en, m_valid, busy, wrap_err;
  logic [W-1:0] ctr_block, m_data;
  int checks = 0, errors = 0, cyc = 0, mode = 0;
  logic [W-1:0] iv_m = '0;
  longint n = 0;
  bit wrapped = 1'b0;
  exp_t exp_q[$];
  core_t core_q[$];

  prince_ctr_ctrl dut (
    .clk(clk), .sys_rst(sys_rst), .start(start), .stop(stop), .iv_in(iv_in),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .cipher_gen_en(cipher_gen_en), .ctr_block(ctr_block), .cipher_text(cipher_text),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .busy(busy), .wrap_err(wrap_err)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] ks(input logic [W-1:0] b);
    logic [W-1:0] sw;
    sw = {b[31:0], b[63:32]};
    return (b * 64'h9E3779B97F4A7C15) ^ sw;
  endfunction

  function automatic logic [W-1:0] r64();
    return {$urandom, $urandom};
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] ev);
    checks++;
    assert (obs === ev) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, ev);
    end
  endtask

  task automatic zero_check(input string tag);
    chk({tag, "_s_ready"}, s_ready, 0);
    chk({tag, "_gen_en"}, cipher_gen_en, 0);
    chk({tag, "_ctr_block"}, ctr_block, 0);
    chk({tag, "_m_valid"}, m_valid, 0);
    chk({tag, "_m_data"}, m_data, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_wrap_err"}, wrap_err, 0);
  endtask

  // One clock cycle: check at the falling edge against the model, then advance the model and core.
  task automatic cycle();
    logic rdy, iss;
    logic [W-1:0] blk;
    int occ0;
    exp_t e;
    core_t c;
    @(negedge clk);
    occ0 = exp_q.size();
    rdy = (mode == 1) && (occ0 < DEPTH) && !wrapped;
    iss = s_valid && rdy;
    chk("s_ready", s_ready, rdy);
    chk("gen_en", cipher_gen_en, iss);
    chk("busy", busy, mode != 0);
    chk("wrap_err", wrap_err, wrapped);
    blk = iv_m;
    blk[CW-1:0] = iv_m[CW-1:0] + CW'(n);
    if (iss) begin
      chk("ctr_block", ctr_block, blk);
      e.data = s_data ^ ks(blk);
      e.due = cyc + LAT + 1;
      exp_q.push_back(e);
      c.ks = ks(blk);
      c.due = cyc + LAT;
      core_q.push_back(c);
      n++;
`ifdef PRINCE_CTR_WRAP_GUARD_EN
      if (blk[CW-1:0] == {CW{1'b1}}) wrapped = 1'b1;
`endif
    end
    if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      chk("m_valid", m_valid, 1);
      chk("m_data", m_data, exp_q[0].data);
      if (m_ready) e = exp_q.pop_front();
    end else chk("m_valid", m_valid, 0);
    if (mode == 0 && start) begin
      mode = 1;
      iv_m = iv_in;
      n = 0;
      wrapped = 1'b0;
    end else if (mode == 1 && stop) mode = 2;
    else if (mode == 2 && occ0 == 0) mode = 0;
    @(posedge clk);
    #1;
    cyc++;
    if (core_q.size() > 0 && core_q[0].due == cyc) begin
      c = core_q.pop_front();
      cipher_text = c.ks;
    end else cipher_text = r64();
  endtask

  task automatic start_run(input logic [W-1:0] iv);
    iv_in = iv;
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic stop_drain();
    s_valid = 1'b0;
    m_ready = 1'b1;
    stop = 1'b1;
    cycle();
    stop = 1'b0;
    repeat (20) cycle();
    chk("idle_after_drain", busy, 0);
  endtask

  initial begin
    #1 sys_rst = 1'b1;
    #1 zero_check("por");
    repeat (2) cycle();
    sys_rst = 1'b0;
    cycle();
    // single block, zero data exposes the raw keystream
    m_ready = 1'b1;
    start_run(64'h0123456789ABCDEF);
    s_valid = 1'b1;
    s_data = '0;
    cycle();
    s_valid = 1'b0;
    repeat (8) cycle();
    stop_drain();
    // 20-word back-to-back burst
    start_run(64'h0123456789ABCDEF);
    for (int i = 0; i < 20; i++) begin
      s_valid = 1'b1;
      s_data = r64();
      cycle();
    end
    s_valid = 1'b0;
    repeat (8) cycle();
    // backpressure, with a start pulse in RUN that must be ignored
    m_ready = 1'b0;
    s_valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      s_data = r64();
      start = (i == 10);
      iv_in = r64();
      cycle();
    end
    start = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      s_data = r64();
      cycle();
    end
    // random valid/ready traffic
    for (int i = 0; i < 80; i++) begin
      s_valid = 1'($urandom_range(0, 1));
      s_data = r64();
      m_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    stop_drain();
    // counter field wraps, upper half untouched
    start_run(64'h01234567FFFFFFFE);
    s_valid = 1'b1;
    repeat (3) begin
      s_data = r64();
      cycle();
    end
    s_valid = 1'b0;
    repeat (8) cycle();
    stop_drain();
    // stop in IDLE ignored; start with stop in IDLE: start wins
    stop = 1'b1;
    cycle();
    iv_in = r64();
    start = 1'b1;
    cycle();
    start = 1'b0;
    stop = 1'b0;
    // stop with three blocks in flight, input held valid during drain
    s_valid = 1'b1;
    repeat (3) begin
      s_data = r64();
      cycle();
    end
    s_valid = 1'b0;
    stop = 1'b1;
    cycle();
    stop = 1'b0;
    s_valid = 1'b1;
    repeat (15) cycle();
    s_valid = 1'b0;
    chk("stop_drain_idle", busy, 0);
    cycle();
    // async reset mid-burst, then restart from counter zero
    start_run(64'hFEDCBA9876543210);
    s_valid = 1'b1;
    repeat (6) begin
      s_data = r64();
      cycle();
    end
    #2 sys_rst = 1'b1;
    #1 zero_check("async_rst");
    s_valid = 1'b0;
    mode = 0;
    n = 0;
    wrapped = 1'b0;
    iv_m = '0;
    exp_q.delete();
    core_q.delete();
    repeat (2) cycle();
    sys_rst = 1'b0;
    start_run(64'hFEDCBA9876543210);
    s_valid = 1'b1;
    repeat (3) begin
      s_data = r64();
      cycle();
    end
    s_valid = 1'b0;
    repeat (8) cycle();
    stop_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
